// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM with ALU-control decode for the execution stage.
// Latency: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles; each mem_ready wait cycle adds one.
// Backpressure: FETCH, MEMRD and MEMWR hold their state and strobes until mem_ready is seen.
module mips_mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic [3:0]       aluctrl,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     state;
    state_t     state_nxt;
    logic       funct_ok;
    logic [3:0] funct_alu;
    logic       ill_nxt;
    logic       retire;

    // Raw Moore strobes; gated by rst_n below so nothing fires while reset is held.
    logic mem_read_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic pc_en_raw;

    // Funct field to ALU operation, with a flag for supported R-type functions.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000, 6'b100001: funct_alu = ALU_ADD;
            6'b100010, 6'b100011: funct_alu = ALU_SUB;
            6'b100100:            funct_alu = ALU_AND;
            6'b100101:            funct_alu = ALU_OR;
            6'b101010:            funct_alu = ALU_SLT;
            default:              funct_ok  = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; every output defaults to its idle value first.
    always_comb begin
        state_nxt     = state;
        iord          = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        pc_en_raw     = 1'b0;
        aluctrl       = ALU_ADD;
        ill_nxt       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = 2'b01;
                ir_write_raw = mem_ready;
                pc_en_raw    = mem_ready;
                if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDI_EX;
                    default: begin
                        state_nxt = S_FETCH;
                        ill_nxt   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Only lw/sw reach here; anything but lw is treated as a store.
                state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                aluctrl   = funct_alu;
                if (funct_ok) begin
                    state_nxt = S_RWB;
                end else begin
                    state_nxt = S_FETCH;
                    ill_nxt   = 1'b1;
                end
            end
            S_RWB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluctrl   = ALU_SUB;
                pc_src    = 2'b01;
                pc_en_raw = zero;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_src    = 2'b10;
                pc_en_raw = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nxt = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_raw = 1'b1;
                state_nxt     = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // An instruction retires when a completing state hands back to FETCH.
    always_comb begin
        retire = 1'b0;
        if (state_nxt == S_FETCH) begin
            case (state)
                S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    // Strobes are combinationally killed by reset so an async assert cannot leave one high.
    assign mem_read  = mem_read_raw  & rst_n;
    assign mem_write = mem_write_raw & rst_n;
    assign ir_write  = ir_write_raw  & rst_n;
    assign reg_write = reg_write_raw & rst_n;
    assign pc_en     = pc_en_raw     & rst_n;

    // Illegal-op pulse register and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            illegal_op <= ill_nxt;
            if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: per-instruction expected output traces built from the ISA rules.
// Runs directed scenarios then randomized instruction streams with random memory waits.
// Counter is instantiated 4 bits wide so wrap-around is reachable quickly.
module tb_mips_mc_control;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic             pc_en;
    logic [3:0]       aluctrl;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    int n_vec = 0;
    int n_bad = 0;
    int cnt   = 0;          // reference retired count (mod 2^CNT_W)
    logic ill_pending = 1'b0; // reference: illegal pulse due in the next cycle

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] AND_ = 4'b0000;
    localparam logic [3:0] OR_ = 4'b0001;
    localparam logic [3:0] SLT = 4'b0111;

    mips_mc_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_en(pc_en), .aluctrl(aluctrl), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Output bundle: {iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
    //                 alu_src_a,alu_src_b,pc_src,pc_en,aluctrl}
    function automatic logic [16:0] ov(input logic io, input logic mr, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ps, input logic pe,
                                       input logic [3:0] alu);
        return {io, mr, mw, irw, rd, m2r, rw, sa, sb, ps, pe, alu};
    endfunction

    // Supported R-type functions and their ALU operation.
    function automatic logic funct_valid(input logic [5:0] f);
        return f inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                         6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [3:0] funct_op(input logic [5:0] f);
        if (f == 6'b100000 || f == 6'b100001) return ADD;
        if (f == 6'b100010 || f == 6'b100011) return SUB;
        if (f == 6'b100100) return AND_;
        if (f == 6'b100101) return OR_;
        if (f == 6'b101010) return SLT;
        return ADD;
    endfunction

    // One clock of stimulus and output check; inputs change just after a falling edge.
    task automatic step(input logic mr, input logic z, input logic [16:0] exp, input string nm);
        logic [17:0] got;
        logic [17:0] want;
        mem_ready = mr;
        zero      = z;
        #1;
        got  = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, pc_src, pc_en, aluctrl, illegal_op};
        want = {exp, ill_pending};
        ill_pending = 1'b0;
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, got, want);
        end
        @(negedge clk);
    endtask

    // Run one whole instruction and check every cycle plus the retired count afterward.
    task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int fw, input int mw);
        opcode = op;
        funct  = fn;
        for (int i = 0; i < fw; i++)
            step(1'b0, 1'($urandom), ov(0,1,0,0,0,0,0,0,2'b01,2'b00,0,ADD), "fetch_wait");
        step(1'b1, 1'($urandom), ov(0,1,0,1,0,0,0,0,2'b01,2'b00,1,ADD), "fetch_ready");
        step(1'($urandom), 1'($urandom), ov(0,0,0,0,0,0,0,0,2'b11,2'b00,0,ADD), "decode");
        case (op)
            6'b000000: begin
                step(1'($urandom), 1'($urandom),
                     ov(0,0,0,0,0,0,0,1,2'b00,2'b00,0,funct_op(fn)), "exec");
                if (funct_valid(fn)) begin
                    step(1'($urandom), 1'($urandom), ov(0,0,0,0,1,0,1,0,2'b00,2'b00,0,ADD), "rwb");
                    cnt = (cnt + 1) % (1 << CNT_W);
                end else begin
                    ill_pending = 1'b1;
                end
            end
            6'b100011, 6'b101011: begin
                step(1'($urandom), 1'($urandom), ov(0,0,0,0,0,0,0,1,2'b10,2'b00,0,ADD), "memadr");
                for (int i = 0; i <= mw; i++) begin
                    if (op == 6'b100011)
                        step(i == mw, 1'($urandom), ov(1,1,0,0,0,0,0,0,2'b00,2'b00,0,ADD), "memrd");
                    else
                        step(i == mw, 1'($urandom), ov(1,0,1,0,0,0,0,0,2'b00,2'b00,0,ADD), "memwr");
                end
                if (op == 6'b100011)
                    step(1'($urandom), 1'($urandom), ov(0,0,0,0,0,1,1,0,2'b00,2'b00,0,ADD), "memwb");
                cnt = (cnt + 1) % (1 << CNT_W);
            end
            6'b000100: begin
                step(1'($urandom), z, ov(0,0,0,0,0,0,0,1,2'b00,2'b01,z,SUB), "branch");
                cnt = (cnt + 1) % (1 << CNT_W);
            end
            6'b000010: begin
                step(1'($urandom), 1'($urandom), ov(0,0,0,0,0,0,0,0,2'b00,2'b10,1,ADD), "jump");
                cnt = (cnt + 1) % (1 << CNT_W);
            end
            6'b001000: begin
                step(1'($urandom), 1'($urandom), ov(0,0,0,0,0,0,0,1,2'b10,2'b00,0,ADD), "addi_ex");
                step(1'($urandom), 1'($urandom), ov(0,0,0,0,0,0,1,0,2'b00,2'b00,0,ADD), "addi_wb");
                cnt = (cnt + 1) % (1 << CNT_W);
            end
            default: ill_pending = 1'b1;
        endcase
        #1;
        n_vec++;
        if (instr_count !== CNT_W'(cnt)) begin
            n_bad++;
            $display("FAIL instr_count: got %0d expected %0d", instr_count, cnt);
        end
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({mem_read, mem_write, ir_write, reg_write, pc_en, illegal_op} !== 6'b0 ||
            instr_count !== '0) begin
            n_bad++;
            $display("FAIL reset_state: strobes/ill %b count %0d expected 0/0",
                     {mem_read, mem_write, ir_write, reg_write, pc_en, illegal_op}, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        ill_pending = 1'b0;
    endtask

    task automatic test_rtype_add;
        exec_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
    endtask

    task automatic test_lw_waits;
        exec_instr(6'b100011, 6'b000000, 1'b0, 2, 3);
    endtask

    task automatic test_beq;
        exec_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        exec_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    endtask

    task automatic test_funct_sweep;
        exec_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
        exec_instr(6'b000000, 6'b100100, 1'b0, 0, 0);
        exec_instr(6'b000000, 6'b100101, 1'b0, 0, 0);
        exec_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
        exec_instr(6'b000000, 6'b000011, 1'b0, 0, 0);
        // One wait cycle in FETCH shows the pulse lasts exactly one cycle.
        exec_instr(6'b001000, 6'b000000, 1'b0, 1, 0);
    endtask

    task automatic test_illegal_opcode;
        exec_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        exec_instr(6'b101011, 6'b000000, 1'b0, 1, 1);
    endtask

    task automatic test_reset_clears_pulse;
        exec_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        mem_ready = 1'b0;
        #1;
        n_vec++;
        if (illegal_op !== 1'b1) begin
            n_bad++;
            $display("FAIL ill_before_reset: got %b expected 1", illegal_op);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (illegal_op !== 1'b0 || mem_read !== 1'b0) begin
            n_bad++;
            $display("FAIL ill_cleared_by_reset: ill %b mem_read %b expected 0 0", illegal_op, mem_read);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        ill_pending = 1'b0;
    endtask

    task automatic test_reset_in_memwr;
        exec_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
        opcode = 6'b101011;
        step(1'b1, 1'b0, ov(0,1,0,1,0,0,0,0,2'b01,2'b00,1,ADD), "sw_fetch");
        step(1'b0, 1'b0, ov(0,0,0,0,0,0,0,0,2'b11,2'b00,0,ADD), "sw_decode");
        step(1'b0, 1'b0, ov(0,0,0,0,0,0,0,1,2'b10,2'b00,0,ADD), "sw_memadr");
        step(1'b0, 1'b0, ov(1,0,1,0,0,0,0,0,2'b00,2'b00,0,ADD), "sw_memwr_wait");
        mem_ready = 1'b0;
        #1;
        n_vec++;
        if (mem_write !== 1'b1) begin
            n_bad++;
            $display("FAIL memwr_hold: mem_write %b expected 1", mem_write);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({mem_write, mem_read, ir_write, reg_write, pc_en} !== 5'b0) begin
            n_bad++;
            $display("FAIL memwr_reset_strobes: got %b expected 00000",
                     {mem_write, mem_read, ir_write, reg_write, pc_en});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        ill_pending = 1'b0;
        #1;
        n_vec++;
        if (instr_count !== '0) begin
            n_bad++;
            $display("FAIL count_after_reset: got %0d expected 0", instr_count);
        end
        #1;
    endtask

    task automatic test_count_wrap;
        for (int i = 0; i < 16; i++)
            exec_instr(6'b000010, 6'b000000, 1'b0, int'($urandom_range(0, 1)), 0);
    endtask

    task automatic test_random_stream;
        logic [5:0] op;
        logic [5:0] fn;
        for (int i = 0; i < 80; i++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 7))
                0: begin op = 6'b000000; fn = {3'b100, 3'($urandom_range(0, 5))}; end
                1: op = 6'b000000;
                2: op = 6'b100011;
                3: op = 6'b101011;
                4: op = 6'b000100;
                5: op = 6'b000010;
                6: op = 6'b001000;
                default: begin
                    op = 6'($urandom);
                    while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                      6'b000010, 6'b001000})
                        op = 6'($urandom);
                end
            endcase
            exec_instr(op, fn, 1'($urandom), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset;
        test_rtype_add;
        test_lw_waits;
        test_beq;
        test_funct_sweep;
        test_illegal_opcode;
        test_reset_clears_pulse;
        test_reset_in_memwr;
        test_count_wrap;
        test_random_stream;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
